// File: rtl/multmod_seq_if.sv
// Dispatch-side and datapath-side signals of the multmod pass sequencer.
// The slave modport is the sequencer; the master modport is the driving side.
interface multmod_seq_if;
  logic       fpuhold;
  logic       start;
  logic       dbl;
  logic       movf;
  logic [3:0] nx_multfunc_rom0;
  logic [3:0] nx_multfunc_rom1;
  logic [1:0] romsel;
  logic       nx_cyc0_rdy;
  logic       busy;
  logic       done;
  logic       ovf;

  modport slave (
    input  fpuhold, start, dbl, movf,
    output nx_multfunc_rom0, nx_multfunc_rom1, romsel, nx_cyc0_rdy, busy, done, ovf
  );

  modport master (
    output fpuhold, start, dbl, movf,
    input  nx_multfunc_rom0, nx_multfunc_rom1, romsel, nx_cyc0_rdy, busy, done, ovf
  );
endinterface

// File: rtl/multmod_seq.sv
// Pass sequencer for the FPU mantissa multiplier: issues ping-pong function
// codes for a single (1 pass) or double (4 passes) multiply, then pulses done.
module multmod_seq #(
  parameter int DRAIN = 2
) (
  input  logic         clk,
  input  logic         reset_l,
  multmod_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CYC0,
    S_PASS,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [2:0] DRAIN_LD = 3'(DRAIN - 1);

  state_e     state_q, state_d;
  logic [1:0] p_q, p_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbl_q, dbl_d;
  logic       ovf_q, ovf_d;

  logic [3:0] rom0, rom1;
  logic [1:0] romsel;
  logic [3:0] code_act, code_nxt;
  logic       last_pass;

  // Code for pass p: double issues 1..4, single issues 5; past the list is NOP.
  function automatic logic [3:0] pass_code(input logic dbl, input logic [2:0] p);
    if (dbl) return (p < 3'd4) ? 4'({1'b0, p} + 4'd1) : 4'd0;
    return (p == 3'd0) ? 4'd5 : 4'd0;
  endfunction

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      p_q     <= 2'd0;
      cnt_q   <= 3'd0;
      dbl_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dbl_q   <= dbl_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    dbl_d     = dbl_q;
    ovf_d     = ovf_q;
    last_pass = dbl_q ? (p_q == 2'd3) : (p_q == 2'd0);

    if (!bus.fpuhold) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_CYC0;
            dbl_d   = bus.dbl;
            ovf_d   = 1'b0;
            p_d     = 2'd0;
          end
        end
        S_CYC0: state_d = S_PASS;
        S_PASS: begin
          if (last_pass) begin
            // A one-cycle drain has no DRAIN state at all.
            state_d = (DRAIN == 1) ? S_DONE : S_DRAIN;
            cnt_d   = DRAIN_LD;
          end else begin
            p_d = 2'(p_q + 2'd1);
          end
        end
        S_DRAIN: begin
          cnt_d = 3'(cnt_q - 3'd1);
          if (cnt_q <= 3'd1) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
          ovf_d   = bus.movf;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so a hold freezes them too.
  always_comb begin
    rom0     = 4'd0;
    rom1     = 4'd0;
    romsel   = 2'b00;
    code_act = pass_code(dbl_q, {1'b0, p_q});
    code_nxt = pass_code(dbl_q, 3'({1'b0, p_q} + 3'd1));
    case (state_q)
      S_CYC0: begin
        rom0 = pass_code(dbl_q, 3'd0);
        rom1 = pass_code(dbl_q, 3'd1);
      end
      S_PASS: begin
        if (p_q[0]) begin
          romsel = 2'b10;
          rom1   = code_act;
          rom0   = code_nxt;
        end else begin
          romsel = 2'b01;
          rom0   = code_act;
          rom1   = code_nxt;
        end
      end
      default: ;
    endcase
  end

  assign bus.nx_multfunc_rom0 = rom0;
  assign bus.nx_multfunc_rom1 = rom1;
  assign bus.romsel           = romsel;
  assign bus.nx_cyc0_rdy      = (state_q == S_CYC0);
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.done             = (state_q == S_DONE);
  assign bus.ovf              = ovf_q;

endmodule

// File: tb/tb_multmod_seq.sv
// Bench for multmod_seq: a timeline model (cycles since acceptance) predicts
// every output each cycle, with directed literal checks pinning the model.
module tb_multmod_seq;
  localparam int DRAIN_P = 2;

  typedef struct packed {
    logic [3:0] r0;
    logic [3:0] r1;
    logic [1:0] sel;
    logic       cyc0;
    logic       busy;
    logic       done;
    logic       ovf;
  } outs_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  multmod_seq_if bus ();

  multmod_seq #(.DRAIN(DRAIN_P)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: t_m = cycles since the accepted start (0 = idle), frozen by fpuhold.
  int   t_m = 0;
  logic dbl_m = 1'b0;
  logic ovf_m = 1'b0;
  int   n_acc = 0;

  function automatic int op_len(input logic d);
    return 1 + (d ? 4 : 1) + DRAIN_P;
  endfunction

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      t_m   <= 0;
      ovf_m <= 1'b0;
    end else if (!bus.fpuhold) begin
      if (t_m == 0) begin
        if (bus.start) begin
          t_m   <= 1;
          dbl_m <= bus.dbl;
          ovf_m <= 1'b0;
          n_acc <= n_acc + 1;
        end
      end else if (t_m == op_len(dbl_m)) begin
        t_m   <= 0;
        ovf_m <= bus.movf;
      end else begin
        t_m <= t_m + 1;
      end
    end
  end

  function automatic logic [3:0] code(input logic d, input int p);
    int dbl_list [4] = '{1, 2, 3, 4};
    if (d) return (p >= 0 && p < 4) ? 4'(dbl_list[p]) : 4'd0;
    return (p == 0) ? 4'd5 : 4'd0;
  endfunction

  function automatic outs_t model_out(input int t, input logic d, input logic o);
    outs_t e;
    int n;
    int p;
    e      = '0;
    n      = d ? 4 : 1;
    e.ovf  = o;
    e.busy = (t != 0);
    if (t == 1) begin
      e.cyc0 = 1'b1;
      e.r0   = code(d, 0);
      e.r1   = code(d, 1);
    end else if (t >= 2 && t <= 1 + n) begin
      p = t - 2;
      if (p % 2 == 0) begin
        e.sel = 2'b01;
        e.r0  = code(d, p);
        e.r1  = code(d, p + 1);
      end else begin
        e.sel = 2'b10;
        e.r1  = code(d, p);
        e.r0  = code(d, p + 1);
      end
    end
    e.done = (t == 1 + n + DRAIN_P);
    return e;
  endfunction

  function automatic outs_t dut_now();
    outs_t o;
    o.r0   = bus.nx_multfunc_rom0;
    o.r1   = bus.nx_multfunc_rom1;
    o.sel  = bus.romsel;
    o.cyc0 = bus.nx_cyc0_rdy;
    o.busy = bus.busy;
    o.done = bus.done;
    o.ovf  = bus.ovf;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    outs_t e;
    outs_t a;
    e = model_out(t_m, dbl_m, ovf_m);
    a = dut_now();
    chk("model.rom0",   32'(a.r0),   32'(e.r0));
    chk("model.rom1",   32'(a.r1),   32'(e.r1));
    chk("model.romsel", 32'(a.sel),  32'(e.sel));
    chk("model.cyc0",   32'(a.cyc0), 32'(e.cyc0));
    chk("model.busy",   32'(a.busy), 32'(e.busy));
    chk("model.done",   32'(a.done), 32'(e.done));
    chk("model.ovf",    32'(a.ovf),  32'(e.ovf));
  endtask

  // One edge, then compare outputs mid-cycle; inputs change only at negedges.
  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  outs_t trc [16];

  task automatic run_op(input logic d, input logic mv, input bit hold, output int done_k);
    bus.start = 1'b1;
    bus.dbl   = d;
    bus.movf  = mv;
    done_k    = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      trc[k] = dut_now();
      if (done_k == 0 && trc[k].done) done_k = k;
      bus.start   = 1'b0;
      bus.dbl     = 1'($urandom);
      bus.fpuhold = hold && k >= 3 && k <= 5;
    end
    bus.fpuhold = 1'b0;
  endtask

  initial begin
    int dk;
    int acc0;
    int done0;
    int n_done;
    outs_t a;

    bus.fpuhold = 1'b0;
    bus.start   = 1'b0;
    bus.dbl     = 1'b0;
    bus.movf    = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'($urandom);
      bus.dbl   = 1'($urandom);
      bus.movf  = 1'($urandom);
      tick();
    end
    a = dut_now();
    chk("rst.outputs", 32'(a), 32'd0);
    bus.start = 1'b0;
    reset_l   = 1'b1;
    tick();
    tick();

    // Double, no hold.
    run_op(1'b1, 1'b0, 1'b0, dk);
    chk("dbl.c1.rom0", 32'(trc[1].r0), 32'd1);
    chk("dbl.c1.rom1", 32'(trc[1].r1), 32'd2);
    chk("dbl.c1.cyc0", 32'(trc[1].cyc0), 32'd1);
    chk("dbl.c2.sel",  32'(trc[2].sel), 32'd1);
    chk("dbl.c3.sel",  32'(trc[3].sel), 32'd2);
    chk("dbl.c4.sel",  32'(trc[4].sel), 32'd1);
    chk("dbl.c5.sel",  32'(trc[5].sel), 32'd2);
    chk("dbl.c2.act",  32'(trc[2].r0), 32'd1);
    chk("dbl.c3.act",  32'(trc[3].r1), 32'd2);
    chk("dbl.c4.act",  32'(trc[4].r0), 32'd3);
    chk("dbl.c5.act",  32'(trc[5].r1), 32'd4);
    chk("dbl.done_cycle", 32'(dk), 32'd7);
    for (int k = 1; k <= 7; k++) chk("dbl.busy", 32'(trc[k].busy), 32'd1);
    chk("dbl.c8.busy", 32'(trc[8].busy), 32'd0);

    // Single with overflow.
    run_op(1'b0, 1'b1, 1'b0, dk);
    chk("sgl.c1.rom0", 32'(trc[1].r0), 32'd5);
    chk("sgl.c1.rom1", 32'(trc[1].r1), 32'd0);
    chk("sgl.c2.sel",  32'(trc[2].sel), 32'd1);
    chk("sgl.done_cycle", 32'(dk), 32'd4);
    chk("sgl.ovf_held", 32'(trc[15].ovf), 32'd1);

    // Double with a 3-cycle hold at p=1; ovf clears on the new start.
    run_op(1'b1, 1'b0, 1'b1, dk);
    chk("hold.c1.ovf_cleared", 32'(trc[1].ovf), 32'd0);
    for (int k = 4; k <= 6; k++) begin
      chk("hold.sel", 32'(trc[k].sel), 32'd2);
      chk("hold.rom1", 32'(trc[k].r1), 32'd2);
    end
    chk("hold.done_cycle", 32'(dk), 32'd10);

    // Start while held in IDLE is ignored.
    bus.fpuhold = 1'b1;
    bus.start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("holdidle.busy", 32'(bus.busy), 32'd0);
    end
    bus.start   = 1'b0;
    bus.fpuhold = 1'b0;
    tick();
    tick();
    chk("holdidle.after", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of double pass p=2.
    bus.start = 1'b1;
    bus.dbl   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst.pre.sel",  32'(bus.romsel), 32'd1);
    chk("midrst.pre.rom0", 32'(bus.nx_multfunc_rom0), 32'd3);
    #1 reset_l = 1'b0;
    #1;
    a = dut_now();
    chk("midrst.async", 32'(a), 32'd0);
    tick();
    reset_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst.no_done", 32'(bus.done), 32'd0);
    end

    // Start every cycle, dbl toggling.
    acc0   = n_acc;
    n_done = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.dbl  = 1'(i);
      bus.movf = 1'($urandom);
      tick();
      if (bus.done) n_done++;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) n_done++;
    end
    chk("b2b.done_count", 32'(n_done), 32'(n_acc - acc0));

    // Random traffic with random holds.
    acc0  = n_acc;
    done0 = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.start   = 1'($urandom);
      bus.dbl     = 1'($urandom);
      bus.movf    = 1'($urandom);
      bus.fpuhold = ($urandom_range(5, 0) == 0);
      if (bus.done && !bus.fpuhold) done0++;
    end
    bus.start   = 1'b0;
    bus.fpuhold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) done0++;
    end
    chk("rand.done_count", 32'(done0), 32'(n_acc - acc0));
    chk("rand.idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multmod_seq.md
# multmod_seq

Sequencer for the FPU mantissa multiplier (`multmod`). On a one-cycle start request it issues the pass sequence for a single-precision (1 pass) or double-precision (4 passes) mantissa multiply. It drives the ping-pong function codes, `romsel` and `nx_cyc0_rdy` into `multmod`, waits out the datapath drain, then pulses `done` with a captured overflow flag. It sits between the FPU microcode dispatch and `multmod`, and honours `fpuhold` as a global freeze.

## Interface
- `DRAIN`, default 2: cycles from the last function code until `multout` is valid; legal range 1–7.
- `clk`  in  1  FPU clock; all state changes on the rising edge.
- `reset_l`  in  1  reset, asynchronous, active-low.
- `fpuhold`  in  1  freezes all state and outputs while high.
- `start`  in  1  request pulse; sampled only in IDLE with `fpuhold`=0.
- `dbl`  in  1  precision select, sampled with `start`: 1 = double, 0 = single.
- `movf`  in  1  overflow from `multmod`, valid on the `done` cycle.
- `nx_multfunc_rom0`  out  4  function code, even-pass slot.
- `nx_multfunc_rom1`  out  4  function code, odd-pass slot.
- `romsel`  out  2  active slot: 01 = rom0, 10 = rom1, 00 = none.
- `nx_cyc0_rdy`  out  1  high during the CYC0 state only.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `multout` is valid this cycle.
- `ovf`  out  1  copy of `movf` taken on `done`; holds until the next accepted `start`.

## Operation
- Function codes:
  - 0 = NOP
  - 1 = A0×B0 (clear accumulator)
  - 2 = A0×B1 (accumulate, low pass aligned)
  - 3 = A1×B0 (accumulate)
  - 4 = A1×B1 (accumulate, final)
  - 5 = A1×B1 single (clear accumulator and final)
- Pass lists:
  - Double: 1, 2, 3, 4.
  - Single: 5.
- State machine:
  - States: IDLE, CYC0, PASS, DRAIN, DONE.
  - IDLE → CYC0 on `start`. Capture `dbl`, clear `ovf`, set pass index p=0.
  - CYC0 → PASS unconditionally.
  - PASS: p increments each cycle. Leave to DRAIN after pass 3 (double) or pass 0 (single). Load the drain counter with `DRAIN`-1.
  - DRAIN: decrement the counter; at 0 go to DONE.
  - DONE → IDLE, with `done`=1 and `ovf`←`movf`.
- Ping-pong slots:
  - Pass p executes from slot p[0]: rom0 for even p, rom1 for odd p.
  - `romsel` = 01 when p is even, 10 when p is odd, 00 outside PASS.
  - The inactive slot carries the look-ahead code for pass p+1, or 0 if none.
  - In CYC0, rom0 = code for pass 0 and rom1 = code for pass 1 (0 for single); `romsel` = 00.
  - In IDLE, DRAIN and DONE, both codes are 0.
- `start` outside IDLE, or while `fpuhold`=1, is ignored (not queued).
- `dbl` is ignored except on the accepted `start`.

## Timing
- Reset values: state IDLE; `nx_multfunc_rom0`=0, `nx_multfunc_rom1`=0, `romsel`=00, `nx_cyc0_rdy`=0, `busy`=0, `done`=0, `ovf`=0.
- Reset is asynchronous and may arrive mid-operation. It aborts the operation; no `done` is issued.
- All outputs are registered or decoded from registered state only. No combinational path from `start`, `dbl` or `movf` to any output.
- Latency, with `start` accepted at edge 0 and `fpuhold`=0:
  - CYC0 in cycle 1.
  - PASS in cycles 2..(1+N), where N = 4 (double) or 1 (single).
  - DRAIN for `DRAIN`-1 cycles.
  - `done` in cycle 1+N+`DRAIN`: cycle 5+`DRAIN` for double, 2+`DRAIN` for single.
- A new `start` is accepted at the edge ending the IDLE cycle after `done`, so back-to-back issue costs 1 idle cycle.
- `fpuhold`=1:
  - State, p, the drain counter and `ovf` all hold.
  - Outputs hold their values; a `done` high at hold onset stays high until the hold releases.
  - `movf` is re-sampled on the edge that exits DONE.
- `DRAIN`=1: DRAIN is skipped; the last PASS goes directly to DONE.

## Test plan
- Reset: hold `reset_l`=0 with random inputs → all outputs 0.
  - Assert reset mid-PASS (p=2) → outputs 0 immediately, asynchronously; IDLE on release.
- Double, `DRAIN`=2, `start` at edge 0:
  - Cycle 1: rom0=1, rom1=2, `nx_cyc0_rdy`=1.
  - Cycles 2–5: `romsel` = 01, 10, 01, 10; active codes 1, 2, 3, 4.
  - `done` in cycle 7; `busy` high in cycles 1–7.
- Single, `DRAIN`=2:
  - Cycle 1: rom0=5, rom1=0.
  - Cycle 2: `romsel`=01.
  - `done` in cycle 4, with `movf`=1 → `ovf`=1 holding until the next `start`.
- `fpuhold`: raise for 3 cycles at double pass p=1 → `romsel`=10 and rom1=2 held for the hold duration; `done` delayed by exactly 3 cycles.
  - `start` pulsed while `fpuhold`=1 in IDLE → ignored.
- `start` asserted every cycle with `dbl` toggling:
  - Only IDLE-cycle starts are accepted.
  - Exactly one `done` per accepted start.
  - Each operation's precision follows `dbl` at acceptance.
